// File: rtl/monitor_trace_buffer.sv
// Trace/check endpoint for the datapath monitor taps.
// Verifies diff == a - c and queues timestamped snapshots for a host.
module monitor_trace_buffer #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int TS_W     = 8,
  parameter int MAX_SAMP = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       arm,
  input  logic                       stop,
  input  logic [1:0]                 trig_mode,
  input  logic [DATA_W-1:0]          mon_a,
  input  logic [DATA_W-1:0]          mon_c,
  input  logic                       mon_s,
  input  logic [DATA_W-1:0]          mon_diff,
  output logic [TS_W+3*DATA_W:0]     rd_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [1:0]                 state,
  output logic [$clog2(DEPTH):0]     fill,
  output logic [7:0]                 drop_cnt,
  output logic [15:0]                err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = TS_W + 1 + 3 * DATA_W;
  localparam logic [AW:0] FULL_N = (AW+1)'(DEPTH);
  localparam logic [7:0] SAMP_N = 8'(MAX_SAMP);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } st_t;

  st_t st_q, st_d;

  logic [TS_W-1:0]   ts_q;
  logic [7:0]        samp_q;
  logic              s_prev_q;
  logic              first_q;
  logic [AW:0]       wr_cnt_q;
  logic [AW:0]       rd_cnt_q;
  logic [EW-1:0]     mem [DEPTH];

  logic [DATA_W-1:0] diff_exp;
  logic              mismatch;
  logic              cap_en;
  logic              qual;
  logic              full;
  logic              pop;
  logic              wr;
  logic              drop;
  logic              samp_last;

  // Arm and stop cycles only (re)configure the run; they never sample.
  always_comb begin
    diff_exp = mon_a - mon_c;
    mismatch = mon_diff != diff_exp;
    cap_en   = (st_q == CAPTURE) && !arm && !stop;
    qual     = 1'b0;
    case (trig_mode)
      2'd0:    qual = 1'b1;
      2'd1:    qual = !first_q && (mon_s != s_prev_q);
      2'd2:    qual = mismatch;
      default: qual = 1'b0;
    endcase
    full      = fill == FULL_N;
    pop       = rd_valid && rd_ready;
    wr        = cap_en && qual && (!full || pop);
    drop      = cap_en && qual && full && !pop;
    samp_last = wr && (samp_q + 8'd1 == SAMP_N);
  end

  always_ff @(posedge clk) begin
    if (reset) st_q <= IDLE;
    else       st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    if (arm)
      st_d = CAPTURE;
    else if (st_q == CAPTURE && (stop || samp_last))
      st_d = DONE;
  end

  always_comb begin
    state    = st_q;
    fill     = wr_cnt_q - rd_cnt_q;
    rd_valid = fill != '0;
    rd_data  = rd_valid ? mem[rd_cnt_q[AW-1:0]] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q     <= '0;
      samp_q   <= '0;
      s_prev_q <= 1'b0;
      first_q  <= 1'b0;
      drop_cnt <= '0;
      err_cnt  <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      if (arm) begin
        ts_q     <= '0;
        samp_q   <= '0;
        s_prev_q <= mon_s;
        first_q  <= 1'b1;
        drop_cnt <= '0;
        err_cnt  <= '0;
      end else if (cap_en) begin
        ts_q     <= ts_q + 1'b1;
        s_prev_q <= mon_s;
        first_q  <= 1'b0;
        if (wr)
          samp_q <= samp_q + 8'd1;
        if (mismatch && err_cnt != 16'hFFFF)
          err_cnt <= err_cnt + 16'd1;
        if (drop && drop_cnt != 8'hFF)
          drop_cnt <= drop_cnt + 8'd1;
      end
      if (wr)
        wr_cnt_q <= wr_cnt_q + 1'b1;
      if (pop)
        rd_cnt_q <= rd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr)
      mem[wr_cnt_q[AW-1:0]] <= {ts_q, mon_s, mon_a, mon_c, mon_diff};
  end

endmodule
